seq_approx_divider: RTL and testbench

SEQ_APPROX_DIVIDER -- requirements
Module: seq_approx_divider

---
 rtl/seq_div_pkg.sv | 13 +
 rtl/approx_sub_cell.sv | 14 +
 rtl/seq_approx_divider.sv | 130 +++++++++++++
 tb/tb_seq_approx_divider.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential approximate divider.
package seq_div_pkg;

  localparam int DEF_D_W         = 8;
  localparam int DEF_APPROX_ROWS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/approx_sub_cell.sv
// Approximate one-bit subtractor cell: cheaper logic with a deliberately
// inexact difference and borrow.
module approx_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = (x & ~y) | ((x | y) & ~bin);
  assign bout = ~(x ^ y ^ bin);

endmodule

// File: rtl/seq_approx_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, MSB first.
// SEQ_DIV_APPROX_EN enables approximate subtractor cells on the lowest APPROX_ROWS steps.
module seq_approx_divider
  import seq_div_pkg::*;
#(
  parameter int D_W         = DEF_D_W,
  parameter int N_W         = 2 * D_W,
  parameter int APPROX_ROWS = DEF_APPROX_ROWS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] n,
  input  logic [D_W-1:0] d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] q,
  output logic [D_W-1:0] r,
  output logic           dz
);

`ifdef SEQ_DIV_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  localparam int CW = $clog2(D_W + 1);

  state_t         state, state_nxt;
  logic [D_W-1:0] n_lo;   // remaining low dividend bits, next one at MSB
  logic [D_W-1:0] d_reg;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] quo;
  logic [CW-1:0]  cnt;    // steps left; cnt==0 is the hand-off cycle into DONE
  logic           dz_reg;

  logic [D_W:0]   w;
  logic [D_W-1:0] diff_ex, diff_ap, diff;
  logic [D_W:0]   b_ex, b_ap;
  logic           use_ap, bo, qbit;

  assign w = {rem, n_lo[D_W-1]};

  assign b_ex[0] = 1'b0;
  assign b_ap[0] = 1'b0;

  // Both borrow chains are built; the step index picks which one commits.
  for (genvar i = 0; i < D_W; i++) begin : g_col
    assign diff_ex[i]  = w[i] ^ d_reg[i] ^ b_ex[i];
    assign b_ex[i+1]   = (~w[i] & d_reg[i]) | (~(w[i] ^ d_reg[i]) & b_ex[i]);

    approx_sub_cell u_cell (
      .x    (w[i]),
      .y    (d_reg[i]),
      .bin  (b_ap[i]),
      .diff (diff_ap[i]),
      .bout (b_ap[i+1])
    );
  end

  // Current step k = cnt-1, so k < APPROX_ROWS is cnt <= APPROX_ROWS.
  assign use_ap = APPROX_EN && (int'(cnt) <= APPROX_ROWS);
  assign diff   = use_ap ? diff_ap : diff_ex;
  assign bo     = use_ap ? b_ap[D_W] : b_ex[D_W];
  assign qbit   = w[D_W] | ~bo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lo   <= '0;
      d_reg  <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      dz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_lo   <= n[D_W-1:0];
            rem    <= n[N_W-1:D_W];
            d_reg  <= d;
            dz_reg <= (d == '0);
            cnt    <= CW'(D_W);
          end
        end
        CALC: begin
          if (cnt != '0) begin
            rem  <= qbit ? diff : w[D_W-1:0];
            quo  <= {quo[D_W-2:0], qbit};
            n_lo <= {n_lo[D_W-2:0], 1'b0};
            cnt  <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign q  = quo;
  assign r  = rem;
  assign dz = dz_reg;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed checks of the sequential divider: reset, latency, results, handshake, mid-op reset.
module tb_seq_approx_divider;

  localparam int D_W = 8;
  localparam int N_W = 16;
  localparam int AR  = 2;

`ifdef SEQ_DIV_APPROX_EN
  localparam logic [7:0] Q1000 = 8'd140;
  localparam logic [7:0] R1000 = 8'd20;
`else
  localparam logic [7:0] Q1000 = 8'd142;
  localparam logic [7:0] R1000 = 8'd6;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N_W-1:0] n = '0;
  logic [D_W-1:0] d = '0;
  logic           in_ready, out_valid, dz;
  logic [D_W-1:0] q, r;

  int n_cmp = 0;
  int n_bad = 0;

  seq_approx_divider #(.D_W(D_W), .N_W(N_W), .APPROX_ROWS(AR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [N_W-1:0] nn, input logic [D_W-1:0] dd);
    @(negedge clk);
    n        = nn;
    d        = dd;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) chk("timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("ready_after", 32'(in_ready), 32'd1);
    chk("valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [N_W-1:0] nn, input logic [D_W-1:0] dd,
                     input logic [D_W-1:0] eq, input logic [D_W-1:0] er, input logic edz);
    int lat;
    start_op(nn, dd);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(D_W + 1));
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_r"}, 32'(r), 32'(er));
    chk({tag, "_dz"}, 32'(dz), 32'(edz));
    finish_op();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [N_W-1:0] rn;
    logic [D_W-1:0] rd;

    #12;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_iready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run("n1000", 16'd1000, 8'd7, Q1000, R1000, 1'b0);

`ifndef SEQ_DIV_APPROX_EN
    run("dzero", 16'h1234, 8'd0, 8'hFF, 8'h34, 1'b1);
    run("n255", 16'd255, 8'd16, 8'd15, 8'd15, 1'b0);
    run("nzero", 16'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    run("eq255", 16'h00FF, 8'd255, 8'd1, 8'd0, 1'b0);
    run("maxq", 16'hFEFF, 8'd255, 8'd255, 8'd254, 1'b0);
    run("div1", 16'd100, 8'd1, 8'd100, 8'd0, 1'b0);
    run("ovf", 16'h0500, 8'd3, 8'hFF, 8'd3, 1'b0);
`endif

    // Hold DONE with out_ready low; results must not move and in_valid is ignored.
    start_op(16'd1000, 8'd7);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      n        = 16'(i * 37 + 3);
      d        = 8'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("hold_q", 32'(q), 32'(Q1000));
      chk("hold_r", 32'(r), 32'(R1000));
      chk("hold_ovalid", 32'(out_valid), 32'd1);
      chk("hold_iready", 32'(in_ready), 32'd0);
    end
    finish_op();
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ovalid", 32'(out_valid), 32'd0);
    chk("idle_iready", 32'(in_ready), 32'd1);

    // Reset while step 4 is in flight.
    start_op(16'h1234, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_q", 32'(q), 32'd0);
    chk("mid_r", 32'(r), 32'd0);
    chk("mid_dz", 32'(dz), 32'd0);
    chk("mid_ovalid", 32'(out_valid), 32'd0);
    chk("mid_iready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
`ifndef SEQ_DIV_APPROX_EN
    run("post_rst", 16'd255, 8'd16, 8'd15, 8'd15, 1'b0);

    for (int i = 0; i < 200; i++) begin
      rd = 8'($urandom_range(1, 255));
      rn = {8'($urandom_range(0, int'(rd) - 1)), 8'($urandom_range(0, 255))};
      run("rand", rn, rd, 8'(rn / 16'(rd)), 8'(rn % 16'(rd)), 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
